// File: rtl/trap_if.sv
// Commit-stage / CSR-file side bundle of the trap sequencer: event requests,
// sampled CSR values, the three CSR write ports, fetch redirect and privilege.
interface trap_if #(
  parameter int XLEN = 64
);
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;
  logic            commit_bound;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  logic            req_ready;
  logic            busy;
  logic            wdEn;
  logic            wdEn2;
  logic            wdEn3;
  logic [11:0]     write_target;
  logic [11:0]     write_target2;
  logic [11:0]     write_target3;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] write_data2;
  logic [XLEN-1:0] write_data3;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      priv;

  // Commit stage / CSR file view
  modport master (
    output exc_valid, exc_code, exc_pc, exc_tval, mret_valid, commit_bound,
           next_pc, mip, mie, mstatus, mtvec, mepc,
    input  req_ready, busy, wdEn, wdEn2, wdEn3,
           write_target, write_target2, write_target3,
           write_data, write_data2, write_data3,
           redirect_valid, redirect_pc, priv
  );

  // Trap sequencer view
  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_tval, mret_valid, commit_bound,
           next_pc, mip, mie, mstatus, mtvec, mepc,
    output req_ready, busy, wdEn, wdEn2, wdEn3,
           write_target, write_target2, write_target3,
           write_data, write_data2, write_data3,
           redirect_valid, redirect_pc, priv
  );
endinterface

// File: rtl/trap_unit.sv
// Machine-mode trap sequencer. Accepts an exception, mret or interrupt while
// idle, snapshots the relevant CSRs, then walks a fixed write sequence into
// the CSR file and finishes with a single-cycle fetch redirect.
module trap_unit #(
  parameter int XLEN = 64
) (
  input  logic   clk,
  input  logic   rst,
  trap_if.slave  bus
);

  localparam logic [11:0]     CSR_MSTATUS = 12'h300;
  localparam logic [11:0]     CSR_MEPC    = 12'h341;
  localparam logic [11:0]     CSR_MCAUSE  = 12'h342;
  localparam logic [11:0]     CSR_MTVAL   = 12'h343;
  localparam logic [XLEN-1:0] IRQ_MASK    = XLEN'(12'h888);
  localparam logic [1:0]      PRIV_M      = 2'd3;

  typedef enum logic [1:0] {IDLE, WR0, WR1, REDIR} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      priv_q;

  // Snapshot taken at acceptance; the sequence never looks at live inputs.
  logic            lat_mret;
  logic            lat_int;
  logic [3:0]      lat_cause;
  logic [XLEN-1:0] lat_epc;
  logic [XLEN-1:0] lat_tval;
  logic [XLEN-1:0] lat_mstatus;
  logic [XLEN-1:0] lat_mtvec;
  logic [XLEN-1:0] lat_mepc;

  logic [XLEN-1:0] irq_pend;
  logic            irq_any;
  logic            irq_take;
  logic [3:0]      irq_cause;
  logic            accept;

  // mstatus image on trap entry: stash MIE in MPIE, mask interrupts, record MPP.
  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] ms,
                                                  input logic [1:0] prv);
    logic [XLEN-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = prv;
    return r;
  endfunction

  // mstatus image on mret: restore MIE from MPIE, set MPIE, drop MPP to U.
  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b00;
    return r;
  endfunction

  // Handler address: direct base, or base + 4*cause for vectored interrupts.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic is_int,
                                                  input logic [3:0] cause);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (is_int && (tvec[1:0] == 2'b01)) begin
      base = base + {{(XLEN-6){1'b0}}, cause, 2'b00};
    end
    return base;
  endfunction

  assign irq_pend  = bus.mip & bus.mie & IRQ_MASK;
  assign irq_any   = (|irq_pend) && (bus.mstatus[3] || (priv_q != PRIV_M));
  assign irq_take  = bus.commit_bound && irq_any;
  assign irq_cause = irq_pend[11] ? 4'd11 : (irq_pend[3] ? 4'd3 : 4'd7);
  assign accept    = (state == IDLE) && (bus.exc_valid || bus.mret_valid || irq_take);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Privilege switches at the end of WR0 for both traps and mret.
  always_ff @(posedge clk) begin
    if (rst) begin
      priv_q <= PRIV_M;
    end else if (state == WR0) begin
      priv_q <= lat_mret ? lat_mstatus[12:11] : PRIV_M;
    end
  end

  // Event snapshot; exception outranks mret, which outranks interrupts.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_mstatus <= bus.mstatus;
      lat_mtvec   <= bus.mtvec;
      lat_mepc    <= bus.mepc;
      if (bus.exc_valid) begin
        lat_mret  <= 1'b0;
        lat_int   <= 1'b0;
        lat_cause <= bus.exc_code;
        lat_epc   <= bus.exc_pc;
        lat_tval  <= bus.exc_tval;
      end else if (bus.mret_valid) begin
        lat_mret  <= 1'b1;
        lat_int   <= 1'b0;
        lat_cause <= 4'd0;
        lat_epc   <= '0;
        lat_tval  <= '0;
      end else begin
        lat_mret  <= 1'b0;
        lat_int   <= 1'b1;
        lat_cause <= irq_cause;
        lat_epc   <= bus.next_pc;
        lat_tval  <= '0;
      end
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt          = state;
    bus.wdEn           = 1'b0;
    bus.wdEn2          = 1'b0;
    bus.wdEn3          = 1'b0;
    bus.write_target   = 12'h000;
    bus.write_target2  = 12'h000;
    bus.write_target3  = 12'h000;
    bus.write_data     = '0;
    bus.write_data2    = '0;
    bus.write_data3    = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = WR0;
      end
      WR0: begin
        bus.wdEn3         = 1'b1;
        bus.write_target3 = CSR_MSTATUS;
        if (lat_mret) begin
          bus.write_data3 = mret_status(lat_mstatus);
          state_nxt       = REDIR;
        end else begin
          bus.wdEn          = 1'b1;
          bus.write_target  = CSR_MEPC;
          bus.write_data    = {lat_epc[XLEN-1:2], 2'b00};
          bus.wdEn2         = 1'b1;
          bus.write_target2 = CSR_MCAUSE;
          bus.write_data2   = {lat_int, {(XLEN-5){1'b0}}, lat_cause};
          bus.write_data3   = trap_status(lat_mstatus, priv_q);
          state_nxt         = WR1;
        end
      end
      WR1: begin
        bus.wdEn         = 1'b1;
        bus.write_target = CSR_MTVAL;
        bus.write_data   = lat_tval;
        state_nxt        = REDIR;
      end
      REDIR: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = lat_mret ? lat_mepc
                                      : trap_target(lat_mtvec, lat_int, lat_cause);
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.priv      = priv_q;

endmodule

// File: tb/tb_trap_unit.sv
// Bench for trap_unit: directed scenarios followed by randomized events
// compared against a rule-level reference model.
module tb_trap_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] cur_priv = 2'd3;

  always #5 clk = ~clk;

  trap_if #(.XLEN(64)) bus ();
  trap_unit #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [1:0]  kind;      // 0 none, 1 trap, 2 mret
    logic [63:0] mepc_w;
    logic [63:0] mcause_w;
    logic [63:0] mstatus_w;
    logic [63:0] mtval_w;
    logic [63:0] redir;
    logic [1:0]  priv_after;
  } exp_t;

  // Reference model: what the CSR file should see for one IDLE-cycle input set.
  function automatic exp_t model(input logic exc, input logic mret, input logic bound,
                                 input logic [3:0] code, input logic [63:0] pc,
                                 input logic [63:0] tv, input logic [63:0] npc,
                                 input logic [63:0] mip, input logic [63:0] mie,
                                 input logic [63:0] ms, input logic [63:0] mtvec,
                                 input logic [63:0] mepc, input logic [1:0] prv);
    exp_t e;
    logic [63:0] pend;
    logic        irq;
    logic        is_int;
    logic [3:0]  c;
    e = '0;
    c = 4'd0;
    is_int = 1'b0;
    e.priv_after = prv;
    pend = mip & mie & 64'h888;
    irq  = bound && (pend != 64'd0) && (ms[3] || prv != 2'd3);
    if (exc) begin
      e.kind = 2'd1; c = code; e.mepc_w = pc & ~64'h3; e.mtval_w = tv;
    end else if (mret) begin
      e.kind = 2'd2;
    end else if (irq) begin
      e.kind = 2'd1; is_int = 1'b1;
      c = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
      e.mepc_w = npc & ~64'h3; e.mtval_w = 64'd0;
    end
    if (e.kind == 2'd1) begin
      e.mcause_w   = (is_int ? 64'h8000_0000_0000_0000 : 64'd0) + 64'(c);
      e.mstatus_w  = (ms & ~64'h1888) | (ms[3] ? 64'h80 : 64'h0) | (64'(prv) * 64'h800);
      e.redir      = (mtvec & ~64'h3) + ((is_int && mtvec[1:0] == 2'd1) ? 64'(c) * 4 : 64'd0);
      e.priv_after = 2'd3;
    end else if (e.kind == 2'd2) begin
      e.mstatus_w  = (ms & ~64'h1888) | 64'h80 | (ms[7] ? 64'h8 : 64'h0);
      e.redir      = mepc;
      e.priv_after = ms[12:11];
    end
    return e;
  endfunction

  task automatic set_idle();
    bus.exc_valid = 1'b0; bus.exc_code = 4'd0; bus.exc_pc = '0; bus.exc_tval = '0;
    bus.mret_valid = 1'b0; bus.commit_bound = 1'b0; bus.next_pc = '0;
    bus.mip = '0; bus.mie = '0; bus.mstatus = '0; bus.mtvec = '0; bus.mepc = '0;
  endtask

  task automatic garbage();
    bus.exc_valid = 1'($urandom); bus.exc_code = 4'($urandom);
    bus.exc_pc = {$urandom, $urandom}; bus.exc_tval = {$urandom, $urandom};
    bus.mret_valid = 1'($urandom); bus.commit_bound = 1'($urandom);
    bus.next_pc = {$urandom, $urandom}; bus.mip = {$urandom, $urandom};
    bus.mie = {$urandom, $urandom}; bus.mstatus = {$urandom, $urandom};
    bus.mtvec = {$urandom, $urandom}; bus.mepc = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0d exp 0", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d exp 0", bus.busy); end
    checks++; if ({bus.wdEn, bus.wdEn2, bus.wdEn3} !== 3'b000) begin errors++; $display("FAIL rst_en got %b exp 000", {bus.wdEn, bus.wdEn2, bus.wdEn3}); end
    checks++; if ({bus.write_target, bus.write_target2, bus.write_target3} !== 36'd0) begin errors++; $display("FAIL rst_tgt got %h exp 0", {bus.write_target, bus.write_target2, bus.write_target3}); end
    checks++; if ((bus.write_data | bus.write_data2 | bus.write_data3) !== 64'd0) begin errors++; $display("FAIL rst_data got nonzero exp 0"); end
    checks++; if ({bus.redirect_valid, bus.redirect_pc} !== 65'd0) begin errors++; $display("FAIL rst_redir got %0d/%h exp 0/0", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.priv !== 2'd3) begin errors++; $display("FAIL rst_priv got %0d exp 3", bus.priv); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %0d exp 1", bus.req_ready); end
    cur_priv = 2'd3;
  endtask

  task automatic test_illegal_trap();
    @(negedge clk);
    set_idle();
    bus.exc_valid = 1'b1; bus.exc_code = 4'd2; bus.exc_pc = 64'h8000_0010;
    bus.exc_tval = 64'hDEAD; bus.mtvec = 64'h8000_0100; bus.mstatus = 64'h8;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %0d exp 1", bus.req_ready); end
    @(negedge clk);
    set_idle();
    checks++; if ({bus.wdEn, bus.write_target, bus.write_data} !== {1'b1, 12'h341, 64'h8000_0010}) begin errors++; $display("FAIL ill_mepc got %0d %h %h exp 1 341 80000010", bus.wdEn, bus.write_target, bus.write_data); end
    checks++; if ({bus.wdEn2, bus.write_target2, bus.write_data2} !== {1'b1, 12'h342, 64'd2}) begin errors++; $display("FAIL ill_mcause got %0d %h %h exp 1 342 2", bus.wdEn2, bus.write_target2, bus.write_data2); end
    checks++; if ({bus.wdEn3, bus.write_target3, bus.write_data3} !== {1'b1, 12'h300, 64'h1880}) begin errors++; $display("FAIL ill_mstatus got %0d %h %h exp 1 300 1880", bus.wdEn3, bus.write_target3, bus.write_data3); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ill_busy got %0d exp 1", bus.busy); end
    @(negedge clk);
    checks++; if ({bus.wdEn, bus.write_target, bus.write_data} !== {1'b1, 12'h343, 64'hDEAD}) begin errors++; $display("FAIL ill_mtval got %0d %h %h exp 1 343 dead", bus.wdEn, bus.write_target, bus.write_data); end
    checks++; if ({bus.wdEn2, bus.wdEn3} !== 2'b00) begin errors++; $display("FAIL ill_wr1_idle got %b exp 00", {bus.wdEn2, bus.wdEn3}); end
    @(negedge clk);
    checks++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 64'h8000_0100}) begin errors++; $display("FAIL ill_redir got %0d %h exp 1 80000100", bus.redirect_valid, bus.redirect_pc); end
    @(negedge clk);
    checks++; if ({bus.req_ready, bus.redirect_valid, bus.priv} !== {1'b1, 1'b0, 2'd3}) begin errors++; $display("FAIL ill_done got %b exp 1011", {bus.req_ready, bus.redirect_valid, bus.priv}); end
    cur_priv = 2'd3;
  endtask

  task automatic test_vectored_irq();
    @(negedge clk);
    set_idle();
    bus.commit_bound = 1'b1; bus.mip = 64'h80; bus.mie = 64'h80; bus.mstatus = 64'h8;
    bus.mtvec = 64'h8000_0101; bus.next_pc = 64'h8000_0200;
    @(negedge clk);
    set_idle();
    checks++; if (bus.write_data2 !== 64'h8000_0000_0000_0007) begin errors++; $display("FAIL virq_mcause got %h exp 8000000000000007", bus.write_data2); end
    checks++; if (bus.write_data !== 64'h8000_0200) begin errors++; $display("FAIL virq_mepc got %h exp 80000200", bus.write_data); end
    @(negedge clk);
    checks++; if ({bus.wdEn, bus.write_data} !== {1'b1, 64'd0}) begin errors++; $display("FAIL virq_mtval got %0d %h exp 1 0", bus.wdEn, bus.write_data); end
    @(negedge clk);
    checks++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 64'h8000_011C}) begin errors++; $display("FAIL virq_redir got %0d %h exp 1 8000011c", bus.redirect_valid, bus.redirect_pc); end
    cur_priv = 2'd3;
  endtask

  task automatic test_mret();
    @(negedge clk);
    set_idle();
    bus.mret_valid = 1'b1; bus.mstatus = 64'h80; bus.mepc = 64'h8000_0040;
    @(negedge clk);
    set_idle();
    checks++; if ({bus.wdEn, bus.wdEn2, bus.wdEn3} !== 3'b001) begin errors++; $display("FAIL mret_en got %b exp 001", {bus.wdEn, bus.wdEn2, bus.wdEn3}); end
    checks++; if ({bus.write_target3, bus.write_data3} !== {12'h300, 64'h88}) begin errors++; $display("FAIL mret_mstatus got %h %h exp 300 88", bus.write_target3, bus.write_data3); end
    checks++; if ({bus.write_target, bus.write_data} !== 76'd0) begin errors++; $display("FAIL mret_port1 got %h %h exp 0 0", bus.write_target, bus.write_data); end
    @(negedge clk);
    checks++; if (bus.priv !== 2'd0) begin errors++; $display("FAIL mret_priv got %0d exp 0", bus.priv); end
    checks++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 64'h8000_0040}) begin errors++; $display("FAIL mret_redir got %0d %h exp 1 80000040", bus.redirect_valid, bus.redirect_pc); end
    checks++; if ({bus.wdEn, bus.wdEn2, bus.wdEn3} !== 3'b000) begin errors++; $display("FAIL mret_redir_en got %b exp 000", {bus.wdEn, bus.wdEn2, bus.wdEn3}); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mret_ready got %0d exp 1", bus.req_ready); end
    cur_priv = 2'd0;
  endtask

  task automatic test_priority();
    // priv is U here, so MPP records 0
    @(negedge clk);
    set_idle();
    bus.exc_valid = 1'b1; bus.mret_valid = 1'b1; bus.commit_bound = 1'b1;
    bus.mip = 64'h800; bus.mie = 64'h800; bus.mstatus = 64'h8; bus.exc_code = 4'd5;
    bus.exc_pc = 64'h1004; bus.exc_tval = 64'h77; bus.mtvec = 64'h3000; bus.mepc = 64'h9999;
    @(negedge clk);
    set_idle();
    checks++; if ({bus.write_data, bus.write_data2, bus.write_data3} !== {64'h1004, 64'd5, 64'h80}) begin errors++; $display("FAIL prio_wr0 got %h %h %h exp 1004 5 80", bus.write_data, bus.write_data2, bus.write_data3); end
    @(negedge clk);
    checks++; if ({bus.wdEn, bus.write_target, bus.write_data, bus.redirect_valid} !== {1'b1, 12'h343, 64'h77, 1'b0}) begin errors++; $display("FAIL prio_wr1 got %0d %h %h %0d exp 1 343 77 0", bus.wdEn, bus.write_target, bus.write_data, bus.redirect_valid); end
    @(negedge clk);
    checks++; if (bus.redirect_pc !== 64'h3000) begin errors++; $display("FAIL prio_redir got %h exp 3000", bus.redirect_pc); end
    @(negedge clk);
    // MEI still pending, but MIE is now clear and priv is M
    bus.commit_bound = 1'b1; bus.mip = 64'h800; bus.mie = 64'h800; bus.mstatus = 64'h80;
    @(negedge clk);
    checks++; if ({bus.busy, bus.wdEn, bus.priv} !== {1'b0, 1'b0, 2'd3}) begin errors++; $display("FAIL prio_masked got %b exp 0011", {bus.busy, bus.wdEn, bus.priv}); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL prio_masked2 got %0d exp 0", bus.busy); end
    set_idle();
    cur_priv = 2'd3;
  endtask

  task automatic test_cause11();
    @(negedge clk);
    set_idle();
    bus.commit_bound = 1'b1; bus.mip = 64'h888; bus.mie = 64'h888; bus.mstatus = 64'h8;
    bus.mtvec = 64'h2001; bus.next_pc = 64'h4000_0003;
    @(negedge clk);
    set_idle();
    checks++; if (bus.write_data2 !== 64'h8000_0000_0000_000B) begin errors++; $display("FAIL c11_mcause got %h exp 800000000000000b", bus.write_data2); end
    checks++; if (bus.write_data !== 64'h4000_0000) begin errors++; $display("FAIL c11_mepc got %h exp 40000000", bus.write_data); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.redirect_pc !== 64'h202C) begin errors++; $display("FAIL c11_redir got %h exp 202c", bus.redirect_pc); end
    cur_priv = 2'd3;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_idle();
    bus.exc_valid = 1'b1; bus.exc_code = 4'd1; bus.exc_pc = 64'h500; bus.mtvec = 64'h600;
    @(negedge clk);
    set_idle();
    @(negedge clk);
    checks++; if ({bus.wdEn, bus.write_target} !== {1'b1, 12'h343}) begin errors++; $display("FAIL rmid_wr1 got %0d %h exp 1 343", bus.wdEn, bus.write_target); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.busy, bus.wdEn, bus.redirect_valid, bus.req_ready} !== 4'b0000) begin errors++; $display("FAIL rmid_idle got %b exp 0000", {bus.busy, bus.wdEn, bus.redirect_valid, bus.req_ready}); end
    checks++; if (bus.priv !== 2'd3) begin errors++; $display("FAIL rmid_priv got %0d exp 3", bus.priv); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0d exp 1", bus.req_ready); end
    @(negedge clk);
    checks++; if ({bus.redirect_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL rmid_noredir got %b exp 00", {bus.redirect_valid, bus.busy}); end
    cur_priv = 2'd3;
  endtask

  task automatic test_back_to_back();
    int redirs = 0;
    @(negedge clk);
    set_idle();
    bus.exc_valid = 1'b1; bus.exc_code = 4'd4; bus.exc_pc = 64'h700;
    bus.mtvec = 64'h800; bus.mstatus = 64'h8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.redirect_valid === 1'b1) redirs++;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d got %0d exp 1", k, bus.busy); end
    end
    checks++; if (redirs !== 1) begin errors++; $display("FAIL b2b_redirs got %0d exp 1", redirs); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL b2b_t4 got %b exp 01", {bus.busy, bus.req_ready}); end
    @(negedge clk);
    bus.exc_valid = 1'b0;
    checks++; if ({bus.busy, bus.wdEn, bus.write_target} !== {1'b1, 1'b1, 12'h341}) begin errors++; $display("FAIL b2b_second got %0d %0d %h exp 1 1 341", bus.busy, bus.wdEn, bus.write_target); end
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_end got %0d exp 0", bus.busy); end
    set_idle();
    cur_priv = 2'd3;
  endtask

  task automatic test_random();
    exp_t e;
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      checks++; if ({bus.req_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL rnd%0d_idle got %b exp 10", it, {bus.req_ready, bus.busy}); end
      garbage();
      bus.exc_valid  = ($urandom_range(0, 3) == 0);
      bus.mret_valid = ($urandom_range(0, 3) == 0);
      bus.mstatus    = (bus.mstatus & ~64'h1800) | (($urandom_range(0, 1) == 1) ? 64'h1800 : 64'h0);
      e = model(bus.exc_valid, bus.mret_valid, bus.commit_bound, bus.exc_code, bus.exc_pc,
                bus.exc_tval, bus.next_pc, bus.mip, bus.mie, bus.mstatus, bus.mtvec,
                bus.mepc, cur_priv);
      @(negedge clk);
      if (e.kind == 2'd0) begin
        set_idle();
        checks++; if ({bus.busy, bus.wdEn, bus.wdEn3, bus.priv} !== {3'b000, cur_priv}) begin errors++; $display("FAIL rnd%0d_none got %b exp 000%b", it, {bus.busy, bus.wdEn, bus.wdEn3, bus.priv}, cur_priv); end
      end else begin
        garbage();
        if (e.kind == 2'd1) begin
          checks++; if ({bus.wdEn, bus.write_target, bus.write_data} !== {1'b1, 12'h341, e.mepc_w}) begin errors++; $display("FAIL rnd%0d_mepc got %0d %h %h exp 1 341 %h", it, bus.wdEn, bus.write_target, bus.write_data, e.mepc_w); end
          checks++; if ({bus.wdEn2, bus.write_target2, bus.write_data2} !== {1'b1, 12'h342, e.mcause_w}) begin errors++; $display("FAIL rnd%0d_mcause got %0d %h %h exp 1 342 %h", it, bus.wdEn2, bus.write_target2, bus.write_data2, e.mcause_w); end
        end else begin
          checks++; if ({bus.wdEn, bus.wdEn2, bus.write_data, bus.write_data2} !== 130'd0) begin errors++; $display("FAIL rnd%0d_mret_idle got %0d %0d %h %h exp 0 0 0 0", it, bus.wdEn, bus.wdEn2, bus.write_data, bus.write_data2); end
        end
        checks++; if ({bus.wdEn3, bus.write_target3, bus.write_data3} !== {1'b1, 12'h300, e.mstatus_w}) begin errors++; $display("FAIL rnd%0d_mstatus got %0d %h %h exp 1 300 %h", it, bus.wdEn3, bus.write_target3, bus.write_data3, e.mstatus_w); end
        if (e.kind == 2'd1) begin
          @(negedge clk);
          garbage();
          checks++; if ({bus.wdEn, bus.write_target, bus.write_data, bus.wdEn2, bus.wdEn3} !== {1'b1, 12'h343, e.mtval_w, 2'b00}) begin errors++; $display("FAIL rnd%0d_mtval got %0d %h %h exp 1 343 %h", it, bus.wdEn, bus.write_target, bus.write_data, e.mtval_w); end
        end
        @(negedge clk);
        garbage();
        checks++; if ({bus.redirect_valid, bus.redirect_pc, bus.wdEn, bus.wdEn3} !== {1'b1, e.redir, 2'b00}) begin errors++; $display("FAIL rnd%0d_redir got %0d %h exp 1 %h", it, bus.redirect_valid, bus.redirect_pc, e.redir); end
        checks++; if (bus.priv !== e.priv_after) begin errors++; $display("FAIL rnd%0d_priv got %0d exp %0d", it, bus.priv, e.priv_after); end
        cur_priv = e.priv_after;
      end
    end
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_illegal_trap();
    test_vectored_irq();
    test_mret();
    test_priority();
    test_cause11();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
